regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 78 +++++++
 rtl/regfile_sb.sv | 74 +++++++
 tb/tb_regfile_sb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF  = 2;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bit per register, RAW/WAW hazard detect
// and a registered count of reserved registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NRP    = NRP_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NRP-1:0]         rd_en,
  input  logic [NRP-1:0][AW-1:0] raddr,
  output logic [NRP-1:0]         rd_busy,
  output logic                   hazard,
  output logic [AW:0]            pend_cnt
);

  localparam logic [AW:0] CNT_ONE = 1;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            raw;
  logic            waw;
  logic            rsv_ok;
  logic            wr_clr;
  logic            cnt_inc;
  logic            cnt_dec;

  // A same-cycle writeback to the source satisfies the read when bypassing.
  always_comb begin
    rd_busy = '0;
    raw     = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      rd_busy[i] = (raddr[i] != '0) && busy[raddr[i]] &&
                   !((BYPASS != 0) && we && (waddr == raddr[i]));
      raw        = raw | (rd_en[i] && rd_busy[i]);
    end
  end

  assign waw    = rsv_valid && (rsv_addr != '0) && busy[rsv_addr] &&
                  !(we && (waddr == rsv_addr));
  assign hazard = raw | waw;

  assign rsv_ok = rsv_valid && (rsv_addr != '0) && !hazard;
  assign wr_clr = we && (waddr != '0) && busy[waddr];

  // Reservation applied after the clear so a coinciding reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (we && (waddr != '0)) busy_nxt[waddr] = 1'b0;
    if (rsv_ok)              busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign cnt_inc = rsv_ok && !busy[rsv_addr];
  assign cnt_dec = wr_clr && !(rsv_ok && (rsv_addr == waddr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({cnt_inc, cnt_dec})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Flip-flop register file with multiport combinational reads, optional
// write-to-read forwarding and an attached pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRP    = NRP_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     rsv_valid,
  input  logic [AW-1:0]            rsv_addr,
  input  logic [NRP-1:0]           rd_en,
  input  logic [NRP-1:0][AW-1:0]   raddr,
  output logic [NRP-1:0][XLEN-1:0] rdata,
  output logic [NRP-1:0]           rd_busy,
  output logic                     hazard,
  output logic [AW:0]              pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic            we_act;
  logic            wr_ok;

  // Writes (and their forwarding) are suppressed while reset is held.
  assign we_act = we && !reset;
  assign wr_ok  = we_act && (waddr != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        regs[r] <= '0;
      else if (wr_ok && (waddr == AW'(r)))
        regs[r] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRP; i++) begin
      if (raddr[i] != '0) begin
        if ((BYPASS != 0) && we_act && (waddr == raddr[i]))
          rdata[i] = wdata;
        else
          rdata[i] = regs[raddr[i]];
      end
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRP    (NRP),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .we        (we_act),
    .waddr     (waddr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rd_busy   (rd_busy),
    .hazard    (hazard),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb (forwarding and non-forwarding
// builds) against a behavioural register/pending-set model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = XLEN_DEF;
  localparam int NREG = NREG_DEF;
  localparam int NRP  = NRP_DEF;
  localparam int AW   = AW_DEF;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     we;
  reg_addr_t                waddr;
  xlen_t                    wdata;
  logic                     rsv_valid;
  reg_addr_t                rsv_addr;
  logic [NRP-1:0]           rd_en;
  logic [NRP-1:0][AW-1:0]   raddr;

  logic [NRP-1:0][XLEN-1:0] rdata_b, rdata_n;
  logic [NRP-1:0]           rd_busy_b, rd_busy_n;
  logic                     hazard_b, hazard_n;
  logic [AW:0]              pend_b, pend_n;

  int total = 0;
  int bad   = 0;

  // Model state, index 1 = forwarding build, index 0 = non-forwarding build.
  xlen_t m_regs [2][NREG];
  bit    m_busy [2][NREG];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_b), .rd_busy(rd_busy_b), .hazard(hazard_b), .pend_cnt(pend_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rd_en(rd_en), .raddr(raddr),
    .rdata(rdata_n), .rd_busy(rd_busy_n), .hazard(hazard_n), .pend_cnt(pend_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NREG; r++) begin
        m_regs[b][r] = '0;
        m_busy[b][r] = 1'b0;
      end
  endtask

  function automatic bit we_live();
    return (we === 1'b1) && (reset !== 1'b1);
  endfunction

  function automatic xlen_t exp_rdata(input int b, input reg_addr_t a);
    if (a == 0) return '0;
    if (b == 1 && we_live() && waddr == a) return wdata;
    return m_regs[b][a];
  endfunction

  function automatic bit exp_rd_busy(input int b, input reg_addr_t a);
    if (a == 0) return 1'b0;
    if (b == 1 && we_live() && waddr == a) return 1'b0;
    return m_busy[b][a];
  endfunction

  function automatic bit exp_hazard(input int b);
    bit h = 1'b0;
    for (int i = 0; i < NRP; i++)
      if (rd_en[i] && exp_rd_busy(b, raddr[i])) h = 1'b1;
    if (rsv_valid && rsv_addr != 0 && m_busy[b][rsv_addr] && !(we_live() && waddr == rsv_addr))
      h = 1'b1;
    return h;
  endfunction

  function automatic int exp_pend(input int b);
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_busy[b][r]);
    return n;
  endfunction

  // Clock-edge effect: write clears, an unstalled reservation then sets.
  task automatic model_tick();
    bit hz;
    if (reset) return;
    for (int b = 0; b < 2; b++) begin
      hz = exp_hazard(b);
      if (we && waddr != 0) begin
        m_regs[b][waddr] = wdata;
        m_busy[b][waddr] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 0 && !hz) m_busy[b][rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NRP; i++) begin
      chk($sformatf("%s/rdata_b%0d", tag, i), 64'(rdata_b[i]), 64'(exp_rdata(1, raddr[i])));
      chk($sformatf("%s/rdata_n%0d", tag, i), 64'(rdata_n[i]), 64'(exp_rdata(0, raddr[i])));
      chk($sformatf("%s/busy_b%0d", tag, i), 64'(rd_busy_b[i]), 64'(exp_rd_busy(1, raddr[i])));
      chk($sformatf("%s/busy_n%0d", tag, i), 64'(rd_busy_n[i]), 64'(exp_rd_busy(0, raddr[i])));
    end
    chk({tag, "/hazard_b"}, 64'(hazard_b), 64'(exp_hazard(1)));
    chk({tag, "/hazard_n"}, 64'(hazard_n), 64'(exp_hazard(0)));
    chk({tag, "/pend_b"}, 64'(pend_b), 64'(exp_pend(1)));
    chk({tag, "/pend_n"}, 64'(pend_n), 64'(exp_pend(0)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    rd_en = '0; raddr = '0;
  endtask

  function automatic reg_addr_t rnd_addr();
    if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, NREG - 1));
    return reg_addr_t'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    model_clear();

    // Reset: every register reads zero, nothing pending.
    for (int a = 0; a < NREG; a += 2) begin
      raddr[0] = reg_addr_t'(a);
      raddr[1] = reg_addr_t'(a + 1);
      rd_en = 2'b11;
      #1;
      check_all($sformatf("rst_rd%0d", a));
    end
    chk("rst_pend", 64'(pend_b), 64'd0);
    chk("rst_hazard", 64'(hazard_b), 64'd0);

    // Inputs held across reset release take effect on the first edge after.
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_5A5A;
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    raddr[0] = 5'd3;
    #1 check_all("hold_in_rst");
    cycle();
    reset = 1'b0;
    #1 check_all("hold_rel");
    cycle();
    idle();
    raddr[0] = 5'd3; raddr[1] = 5'd4;
    #1 check_all("hold_after");
    chk("hold_pend", 64'(pend_b), 64'd1);
    chk("hold_x3", 64'(rdata_b[0]), 64'hA5A5_5A5A);
    we = 1'b1; waddr = 5'd4; wdata = 32'h4;
    cycle();

    // Forwarding: new value visible only on the forwarding build.
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr[0] = 5'd5;
    #1 check_all("byp");
    chk("byp_b", 64'(rdata_b[0]), 64'hDEAD_BEEF);
    chk("byp_n_old", 64'(rdata_n[0]), 64'd0);
    cycle();
    we = 1'b0;
    #1 chk("byp_n_new", 64'(rdata_n[0]), 64'hDEAD_BEEF);
    check_all("byp_after");

    // RAW on a reserved register, released by its writeback.
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1 check_all("raw_rsv");
    cycle();
    idle();
    rd_en = 2'b10; raddr[1] = 5'd7;
    #1 check_all("raw_read");
    chk("raw_busy", 64'(rd_busy_b[1]), 64'd1);
    chk("raw_hazard", 64'(hazard_b), 64'd1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12;
    #1 check_all("raw_wb");
    cycle();
    we = 1'b0;
    #1 check_all("raw_done");
    chk("raw_done_hz", 64'(hazard_b), 64'd0);
    chk("raw_done_pend", 64'(pend_b), 64'd0);
    chk("raw_done_data", 64'(rdata_b[1]), 64'h12);

    // Simultaneous write and re-reserve of a busy register.
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    cycle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    raddr[0] = 5'd9;
    #1 check_all("wrsv_same");
    chk("wrsv_hz", 64'(hazard_b), 64'd0);
    cycle();
    idle();
    raddr[0] = 5'd9;
    #1 check_all("wrsv_after");
    chk("wrsv_pend", 64'(pend_b), 64'd1);
    chk("wrsv_busy", 64'(rd_busy_b[0]), 64'd1);
    chk("wrsv_data", 64'(rdata_b[0]), 64'h55);
    we = 1'b1; waddr = 5'd9; wdata = 32'h66;
    cycle();

    // Register zero: never reserved, never written.
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    #1 check_all("x0_same");
    chk("x0_rd", 64'(rdata_b[0]), 64'd0);
    cycle();
    idle();
    #1 check_all("x0_after");
    chk("x0_pend", 64'(pend_b), 64'd0);
    chk("x0_hz", 64'(hazard_b), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 2) != 0);
      waddr     = rnd_addr();
      wdata     = xlen_t'($urandom);
      rsv_valid = ($urandom_range(0, 1) != 0);
      rsv_addr  = rnd_addr();
      rd_en     = NRP'($urandom_range(0, 3));
      raddr[0]  = rnd_addr();
      raddr[1]  = rnd_addr();
      #1 check_all($sformatf("rnd%0d", n));
      cycle();
    end

    // Fill the pending set, then drop it with an asynchronous reset.
    idle();
    reset = 1'b1;
    model_clear();
    #1 check_all("fill_rst");
    cycle();
    reset = 1'b0;
    for (int a = 1; a < NREG; a++) begin
      rsv_valid = 1'b1; rsv_addr = reg_addr_t'(a);
      cycle();
    end
    idle();
    raddr[0] = 5'd1; raddr[1] = 5'd31; rd_en = 2'b11;
    #1 check_all("fill_full");
    chk("fill_pend", 64'(pend_b), 64'(NREG - 1));
    #2 reset = 1'b1;
    model_clear();
    #1 check_all("fill_async");
    chk("fill_async_pend", 64'(pend_b), 64'd0);
    chk("fill_async_busy", 64'(rd_busy_b), 64'd0);
    cycle();
    reset = 1'b0;
    #1 check_all("fill_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
